// File: rtl/nes_poll_reader_pkg.sv
// Shared definitions for the NES controller poll reader: FSM encoding,
// button bit positions and the default shift-clock half-period.
package nes_poll_reader_pkg;

  localparam int HALF_PERIOD_DEFAULT = 150;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_BIT_LOW  = 3'd2,
    ST_BIT_HIGH = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Position of each button in the buttons/pressed vectors.
  typedef enum logic [2:0] {
    BTN_RIGHT  = 3'd0,
    BTN_LEFT   = 3'd1,
    BTN_DOWN   = 3'd2,
    BTN_UP     = 3'd3,
    BTN_START  = 3'd4,
    BTN_SELECT = 3'd5,
    BTN_B      = 3'd6,
    BTN_A      = 3'd7
  } button_t;

  // The ninth shifted bit tells a real controller from a floating line.
  localparam logic [3:0] BIT_PRESENCE = 4'd8;

  // Shift order is A first, so sample k lands in button slot A-k.
  function automatic logic [2:0] button_slot(input logic [2:0] k_lo);
    return 3'(BTN_A) - k_lo;
  endfunction

endpackage

// File: rtl/nes_poll_reader_sync_2ff.sv
// Two-flop synchronizer for the asynchronous controller data line.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_poll_reader.sv
// NES controller reader: on poll, latches the pad, shifts 9 bits, and
// publishes button states, rising-edge flags and controller presence.
//
// state    | meaning
// IDLE     | waiting for poll, lines low
// LATCH    | latch strobe high for two half-periods
// BIT_LOW  | shift clock low; sample data on last cycle
// BIT_HIGH | shift clock high; controller advances to next bit
// DONE     | one-cycle result publish (valid)
module nes_poll_reader
  import nes_poll_reader_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       present,
  output logic       valid,
  output logic       busy
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] LOAD_LATCH = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LOAD_HALF  = CNT_W'(HALF_PERIOD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       k, k_nxt;
  logic             tc;
  logic             sample_bit;
  logic             sample_presence;
  logic             data_sync;
  logic [7:0]       shift_btn;
  logic [7:0]       new_buttons;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (nes_data),
    .q    (data_sync)
  );

  assign tc = (cnt == '0);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    k_nxt           = k;
    sample_bit      = 1'b0;
    sample_presence = 1'b0;
    nes_latch       = 1'b0;
    nes_clk         = 1'b0;
    busy            = 1'b1;
    valid           = 1'b0;

    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (poll) begin
          state_nxt = ST_LATCH;
          cnt_nxt   = LOAD_LATCH;
        end
      end

      ST_LATCH: begin
        nes_latch = 1'b1;
        if (tc) begin
          state_nxt = ST_BIT_LOW;
          cnt_nxt   = LOAD_HALF;
          k_nxt     = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_BIT_LOW: begin
        if (tc) begin
          if (k == BIT_PRESENCE) begin
            sample_presence = 1'b1;
            state_nxt       = ST_DONE;
            cnt_nxt         = '0;
          end else begin
            sample_bit = 1'b1;
            state_nxt  = ST_BIT_HIGH;
            cnt_nxt    = LOAD_HALF;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_BIT_HIGH: begin
        nes_clk = 1'b1;
        if (tc) begin
          state_nxt = ST_BIT_LOW;
          cnt_nxt   = LOAD_HALF;
          k_nxt     = k + 4'd1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        valid     = 1'b1;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
    end
  end

  // A floating line reads 1 on the presence bit; report no buttons then.
  assign new_buttons = data_sync ? 8'h00 : shift_btn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_btn <= '0;
      buttons   <= '0;
      pressed   <= '0;
      present   <= 1'b0;
    end else begin
      pressed <= '0;
      if (sample_bit) begin
        shift_btn[button_slot(k[2:0])] <= ~data_sync;
      end
      if (sample_presence) begin
        present <= ~data_sync;
        buttons <= new_buttons;
        pressed <= new_buttons & ~buttons;
      end
    end
  end

endmodule

// File: doc/nes_poll_reader.md
NES_POLL_READER -- requirements
Module: nes_poll_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 150, meaning the clk cycles per NES clock/latch half-period (legal minimum 4).
REQ-002 SHALL have port clk  input  1  system clock (one clock domain only).
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port poll  input  1  start-transaction request pulse (driven by frame_end).
REQ-005 SHALL have port nes_data  input  1  serial data from the controller, asynchronous, active-low (0 = pressed).
REQ-006 SHALL have port nes_latch  output  1  latch strobe to the controller.
REQ-007 SHALL have port nes_clk  output  1  shift clock to the controller.
REQ-008 SHALL have port buttons  output  8  held states, active-high: [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
REQ-009 SHALL have port pressed  output  8  one-cycle rising-edge flags, same bit order.
REQ-010 SHALL have port present  output  1  controller detected on the last completed transaction.
REQ-011 SHALL have port valid  output  1  one-cycle pulse: buttons, pressed and present updated.
REQ-012 SHALL have port busy  output  1  high while a transaction is in progress.

Function
REQ-013 SHALL pass nes_data through a 2-flop synchronizer; all samples use the synchronized value.
REQ-014 SHALL implement states IDLE, LATCH, BIT_LOW, BIT_HIGH, DONE.
REQ-015 SHALL in IDLE drive nes_latch=0, nes_clk=0, busy=0; poll=1 -> LATCH on the next edge.
REQ-016 SHALL ignore poll in every state except IDLE; no queuing.
REQ-017 SHALL in LATCH drive nes_latch=1 for exactly 2*HALF_PERIOD cycles, then enter BIT_LOW with bit index 0.
REQ-018 SHALL in BIT_LOW drive nes_clk=0 for HALF_PERIOD cycles and sample the synchronized data on the final cycle into bit index k (k=0..8).
REQ-019 SHALL after the BIT_LOW sample go to BIT_HIGH if k<8, or to DONE if k=8.
REQ-020 SHALL in BIT_HIGH drive nes_clk=1 for HALF_PERIOD cycles, then increment k and return to BIT_LOW.
REQ-021 SHALL map raw samples k=0..7 to buttons[7-k] = ~raw.
REQ-022 SHALL treat sample k=8 as presence: present = (raw8 == 0). A genuine controller shifts 0; an open pull-up line reads 1.
REQ-023 SHALL force buttons to 0 when present=0.
REQ-024 SHALL in DONE (one cycle) update buttons, present and pressed = new & ~old_buttons, assert valid=1 for that cycle, then return to IDLE.
REQ-025 SHALL drive pressed=0 in every cycle except the valid cycle.
REQ-026 SHALL give the timing: poll accepted at edge N -> nes_latch high from N+1, and valid high at cycle N+1+19*HALF_PERIOD.
REQ-027 SHALL size the cycle counter to ceil(log2(2*HALF_PERIOD)) bits; it is reloaded on every state entry and never wraps.
REQ-028 SHALL assert busy in LATCH, BIT_LOW, BIT_HIGH and DONE.
REQ-029 SHALL make buttons change only on the valid cycle; they hold otherwise.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge set state=IDLE, nes_latch=0, nes_clk=0, buttons=0, pressed=0, present=0, valid=0, busy=0, counter=0, k=0, and clear the synchronizer flops to 1.
REQ-031 SHALL abort any transaction in progress when reset occurs mid-operation, with no valid pulse and no partial button update.
REQ-032 SHALL treat poll as ignored during the reset cycle.

Structure
REQ-033 SHALL place the state encoding, the bit-index constants (A..Right and PRESENCE=8) and the HALF_PERIOD default in the shared tts package.
REQ-034 SHALL instantiate one sub-module sync_2ff (2-flop synchronizer, reset value 1) for nes_data.

Verification (HALF_PERIOD=4, transaction = 76 cycles)
REQ-035 SHALL test this scenario: controller model returns raw 0111_1110 then 0 -> buttons=8'h81, pressed=8'h81, present=1, valid 77 cycles after the poll edge.
REQ-036 SHALL test this scenario: a repeat poll with the same data -> buttons=8'h81, pressed=8'h00; then raw 1111_1110 -> buttons=8'h01, pressed=8'h00.
REQ-037 SHALL test this scenario: nes_data held 1 (no controller) -> present=0, buttons=8'h00, valid still pulses.
REQ-038 SHALL test this scenario: poll pulses at cycles +10 and +40 of an active transaction -> ignored, exactly one valid, no extra latch.
REQ-039 SHALL test this scenario: rst_n=0 at cycle +30 of a transaction -> next edge all outputs 0, no valid, previous buttons cleared to 0.
REQ-040 SHALL test this scenario: waveform check -> nes_latch high 8 cycles, 8 nes_clk pulses each 4 cycles high, sampling on the last low cycle of each BIT_LOW phase.
